// File: rtl/fl_reclaim.sv
// Retire-side return path for physical register tags: buffers up to 2 freed tags per cycle
// in an in-order circular FIFO and drains up to 2 per cycle to the free list.
// Optional double-free detection is compiled in with FL_RECLAIM_DBLFREE_EN.
module fl_reclaim #(
  parameter int DEPTH  = 8,
  parameter int NUM_PR = 96,
  parameter int TAG_W  = 7
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [1:0]               rob_retire_num,
  input  logic [TAG_W-1:0]         rob_retire_pr0,
  input  logic [TAG_W-1:0]         rob_retire_pr1,
  input  logic                     fl_hold,
  output logic [1:0]               fl_free_num,
  output logic [TAG_W-1:0]         fl_free_pr0,
  output logic [TAG_W-1:0]         fl_free_pr1,
  output logic                     rob_stall,
  output logic [$clog2(DEPTH):0]   pending_count,
  output logic                     err
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [TAG_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             r_err;

  logic [1:0]       w_pop_num;
  logic [1:0]       w_push_num;
  logic [TAG_W-1:0] w_head_pr0;
  logic [TAG_W-1:0] w_head_pr1;
  logic [CNT_W:0]   w_next_count;
  logic             w_range_ok;
  logic             w_room_ok;
  logic             w_dbl;
  logic             w_legal;

  assign w_head_pr0 = r_mem[r_head];
  assign w_head_pr1 = r_mem[r_head + PTR_W'(1)];

  // Drain is decided from registered state only; the free list takes what is shown.
  assign w_pop_num = fl_hold ? 2'd0 :
                     (r_count >= CNT_W'(2)) ? 2'd2 : r_count[1:0];

  always_comb begin
    w_range_ok = 1'b0;
    case (rob_retire_num)
      2'd0: w_range_ok = 1'b1;
      2'd1: w_range_ok = ({1'b0, rob_retire_pr0} < (TAG_W+1)'(NUM_PR));
      2'd2: w_range_ok = ({1'b0, rob_retire_pr0} < (TAG_W+1)'(NUM_PR)) &&
                         ({1'b0, rob_retire_pr1} < (TAG_W+1)'(NUM_PR));
      default: w_range_ok = 1'b0;
    endcase
  end

  assign w_next_count = {1'b0, r_count} - (CNT_W+1)'(w_pop_num) + (CNT_W+1)'(rob_retire_num);
  assign w_room_ok    = (w_next_count <= (CNT_W+1)'(DEPTH));
  assign w_legal      = w_range_ok && w_room_ok && !w_dbl;
  assign w_push_num   = w_legal ? rob_retire_num : 2'd0;

`ifdef FL_RECLAIM_DBLFREE_EN
  logic [NUM_PR-1:0] r_pend;
  logic [NUM_PR-1:0] w_pop_mask;
  logic [NUM_PR-1:0] w_push_mask;

  always_comb begin
    w_pop_mask  = '0;
    w_push_mask = '0;
    for (int i = 0; i < NUM_PR; i++) begin
      if ((w_pop_num != 2'd0) && (w_head_pr0 == TAG_W'(i))) w_pop_mask[i] = 1'b1;
      if ((w_pop_num == 2'd2) && (w_head_pr1 == TAG_W'(i))) w_pop_mask[i] = 1'b1;
      if (((rob_retire_num == 2'd1) || (rob_retire_num == 2'd2)) &&
          (rob_retire_pr0 == TAG_W'(i))) w_push_mask[i] = 1'b1;
      if ((rob_retire_num == 2'd2) && (rob_retire_pr1 == TAG_W'(i))) w_push_mask[i] = 1'b1;
    end
    // A tag popped this cycle may be freed again in the same cycle.
    w_dbl = (|(w_push_mask & r_pend & ~w_pop_mask)) ||
            ((rob_retire_num == 2'd2) && (rob_retire_pr0 == rob_retire_pr1));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_pend <= '0;
    else        r_pend <= (r_pend & ~w_pop_mask) | (w_legal ? w_push_mask : '0);
  end
`else
  assign w_dbl = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_head  <= r_head + PTR_W'(w_pop_num);
      r_tail  <= r_tail + PTR_W'(w_push_num);
      r_count <= r_count - CNT_W'(w_pop_num) + CNT_W'(w_push_num);
      if (!w_legal) r_err <= 1'b1;
    end
  end

  // Storage is not reset; validity is tracked entirely by head/count.
  always_ff @(posedge clock) begin
    if (w_push_num != 2'd0) r_mem[r_tail] <= rob_retire_pr0;
    if (w_push_num == 2'd2) r_mem[r_tail + PTR_W'(1)] <= rob_retire_pr1;
  end

  assign fl_free_num   = w_pop_num;
  assign fl_free_pr0   = (w_pop_num != 2'd0) ? w_head_pr0 : '0;
  assign fl_free_pr1   = (w_pop_num == 2'd2) ? w_head_pr1 : '0;
  assign rob_stall     = ((CNT_W'(DEPTH) - r_count) < CNT_W'(2));
  assign pending_count = r_count;
  assign err           = r_err;

endmodule

// File: tb/tb_fl_reclaim.sv
// Bench for fl_reclaim: directed vector table, hand corner sequences, and random traffic
// checked against a queue-based reference model.
module tb_fl_reclaim;
  localparam int DEPTH  = 8;
  localparam int NUM_PR = 96;
  localparam int TAG_W  = 7;

  logic             clock;
  logic             reset;
  logic [1:0]       rob_retire_num;
  logic [TAG_W-1:0] rob_retire_pr0;
  logic [TAG_W-1:0] rob_retire_pr1;
  logic             fl_hold;
  logic [1:0]       fl_free_num;
  logic [TAG_W-1:0] fl_free_pr0;
  logic [TAG_W-1:0] fl_free_pr1;
  logic             rob_stall;
  logic [3:0]       pending_count;
  logic             err;

  fl_reclaim #(.DEPTH(DEPTH), .NUM_PR(NUM_PR), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset),
    .rob_retire_num(rob_retire_num), .rob_retire_pr0(rob_retire_pr0),
    .rob_retire_pr1(rob_retire_pr1), .fl_hold(fl_hold),
    .fl_free_num(fl_free_num), .fl_free_pr0(fl_free_pr0), .fl_free_pr1(fl_free_pr1),
    .rob_stall(rob_stall), .pending_count(pending_count), .err(err)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int num, p0, p1, hold;
    int e_num, e_p0, e_p1, e_pend, e_stall, e_err;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int q[$];
  bit merr = 1'b0;
  vec_t tbl[31];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t v(int num, int p0, int p1, int hold, int e_num, int e_p0,
                             int e_p1, int e_pend, int e_stall, int e_err);
    vec_t r;
    r.num = num; r.p0 = p0; r.p1 = p1; r.hold = hold;
    r.e_num = e_num; r.e_p0 = e_p0; r.e_p1 = e_p1;
    r.e_pend = e_pend; r.e_stall = e_stall; r.e_err = e_err;
    return r;
  endfunction

  // Reference model: the buffer is just an ordered list of tags.
  function automatic vec_t mk(int num, int p0, int p1, int hold);
    int n = q.size();
    int pop = hold ? 0 : (n < 2 ? n : 2);
    return v(num, p0, p1, hold, pop, (pop >= 1) ? q[0] : 0, (pop == 2) ? q[1] : 0,
             n, ((DEPTH - n) < 2) ? 1 : 0, merr ? 1 : 0);
  endfunction

  task automatic model_cycle(input int num, input int p0, input int p1, input int hold);
    int n = q.size();
    int pop = hold ? 0 : (n < 2 ? n : 2);
    bit legal = 1'b1;
    repeat (pop) void'(q.pop_front());
    if (num > 2) legal = 1'b0;
    if (num >= 1 && p0 >= NUM_PR) legal = 1'b0;
    if (num == 2 && p1 >= NUM_PR) legal = 1'b0;
    if (q.size() + num > DEPTH) legal = 1'b0;
`ifdef FL_RECLAIM_DBLFREE_EN
    foreach (q[i]) begin
      if (num >= 1 && q[i] == p0) legal = 1'b0;
      if (num == 2 && q[i] == p1) legal = 1'b0;
    end
    if (num == 2 && p0 == p1) legal = 1'b0;
`endif
    if (!legal) merr = 1'b1;
    else begin
      if (num >= 1) q.push_back(p0);
      if (num == 2) q.push_back(p1);
    end
  endtask

  // driver: apply one cycle, check pre-edge outputs, advance the model
  task automatic step(input vec_t x);
    @(negedge clock);
    rob_retire_num = 2'(x.num);
    rob_retire_pr0 = 7'(x.p0);
    rob_retire_pr1 = 7'(x.p1);
    fl_hold        = x.hold[0];
    #1;
    chk("free_num",  int'(fl_free_num),   x.e_num);
    chk("free_pr0",  int'(fl_free_pr0),   x.e_p0);
    chk("free_pr1",  int'(fl_free_pr1),   x.e_p1);
    chk("pending",   int'(pending_count), x.e_pend);
    chk("rob_stall", int'(rob_stall),     x.e_stall);
    chk("err",       int'(err),           x.e_err);
    model_cycle(x.num, x.p0, x.p1, x.hold);
  endtask

  task automatic do_reset();
    @(negedge clock);
    rob_retire_num = 2'd0;
    fl_hold = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_pending",  int'(pending_count), 0);
    chk("rst_free_num", int'(fl_free_num),   0);
    chk("rst_stall",    int'(rob_stall),     0);
    chk("rst_err",      int'(err),           0);
    q.delete();
    merr = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    rob_retire_num = 2'd0;
    rob_retire_pr0 = '0;
    rob_retire_pr1 = '0;
    fl_hold = 1'b0;

    //           num p0 p1 hold | num pr0 pr1 pend stall err
    tbl[0]  = v(0,  0,  0, 0,  0,  0,  0, 0, 0, 0);
    tbl[1]  = v(2, 40, 41, 0,  0,  0,  0, 0, 0, 0);
    tbl[2]  = v(0,  0,  0, 0,  2, 40, 41, 2, 0, 0);
    tbl[3]  = v(0,  0,  0, 0,  0,  0,  0, 0, 0, 0);
    tbl[4]  = v(2, 50, 51, 1,  0,  0,  0, 0, 0, 0);
    tbl[5]  = v(2, 52, 53, 1,  0,  0,  0, 2, 0, 0);
    tbl[6]  = v(2, 54, 55, 1,  0,  0,  0, 4, 0, 0);
    tbl[7]  = v(2, 56, 57, 1,  0,  0,  0, 6, 0, 0);
    tbl[8]  = v(0,  0,  0, 1,  0,  0,  0, 8, 1, 0);
    tbl[9]  = v(0,  0,  0, 0,  2, 50, 51, 8, 1, 0);
    tbl[10] = v(0,  0,  0, 0,  2, 52, 53, 6, 0, 0);
    tbl[11] = v(0,  0,  0, 0,  2, 54, 55, 4, 0, 0);
    tbl[12] = v(0,  0,  0, 0,  2, 56, 57, 2, 0, 0);
    tbl[13] = v(0,  0,  0, 0,  0,  0,  0, 0, 0, 0);
    // walk tail to 7, then a pair straddles the wrap
    tbl[14] = v(2,  1,  2, 0,  0,  0,  0, 0, 0, 0);
    tbl[15] = v(2,  3,  4, 0,  2,  1,  2, 2, 0, 0);
    tbl[16] = v(1,  5,  0, 0,  2,  3,  4, 2, 0, 0);
    tbl[17] = v(2, 60, 61, 0,  1,  5,  0, 1, 0, 0);
    tbl[18] = v(0,  0,  0, 0,  2, 60, 61, 2, 0, 0);
    tbl[19] = v(0,  0,  0, 0,  0,  0,  0, 0, 0, 0);
    // overflow at count 7 under hold
    tbl[20] = v(2, 10, 11, 1,  0,  0,  0, 0, 0, 0);
    tbl[21] = v(2, 12, 13, 1,  0,  0,  0, 2, 0, 0);
    tbl[22] = v(2, 14, 15, 1,  0,  0,  0, 4, 0, 0);
    tbl[23] = v(1, 16,  0, 1,  0,  0,  0, 6, 0, 0);
    tbl[24] = v(2, 17, 18, 1,  0,  0,  0, 7, 1, 0);
    tbl[25] = v(0,  0,  0, 1,  0,  0,  0, 7, 1, 1);
    tbl[26] = v(0,  0,  0, 0,  2, 10, 11, 7, 1, 1);
    tbl[27] = v(0,  0,  0, 0,  2, 12, 13, 5, 0, 1);
    tbl[28] = v(0,  0,  0, 0,  2, 14, 15, 3, 0, 1);
    tbl[29] = v(0,  0,  0, 0,  1, 16,  0, 1, 0, 1);
    tbl[30] = v(0,  0,  0, 0,  0,  0,  0, 0, 0, 1);

    do_reset();
    foreach (tbl[i]) step(tbl[i]);

    // illegal count of 3 sets err after a fresh reset
    do_reset();
    step(v(3, 1, 2, 0,  0, 0, 0, 0, 0, 0));
    step(v(0, 0, 0, 0,  0, 0, 0, 0, 0, 1));

    // out-of-range pr1 drops the legal pr0 too
    do_reset();
    step(v(2, 5, 100, 0,  0, 0, 0, 0, 0, 0));
    step(v(0, 0, 0,   0,  0, 0, 0, 0, 0, 1));

    // duplicate tags
    do_reset();
    step(v(1, 70, 0, 1,  0, 0, 0, 0, 0, 0));
    step(v(1, 70, 0, 1,  0, 0, 0, 1, 0, 0));
`ifdef FL_RECLAIM_DBLFREE_EN
    step(v(2, 72, 72, 1,  0, 0, 0, 1, 0, 1));
    step(v(0, 0, 0,   1,  0, 0, 0, 1, 0, 1));
`else
    step(v(2, 72, 72, 1,  0, 0, 0, 2, 0, 0));
    step(v(0, 0, 0,   1,  0, 0, 0, 4, 0, 0));
`endif

    // same-cycle pop and re-free of one tag is legal in every build
    do_reset();
    step(v(1, 80, 0, 0,  0, 0,  0, 0, 0, 0));
    step(v(1, 80, 0, 0,  1, 80, 0, 1, 0, 0));
    step(v(0, 0,  0, 0,  1, 80, 0, 1, 0, 0));

    // reset mid-operation discards buffered tags
    step(v(2, 90, 91, 1,  0, 0, 0, 0, 0, 0));
    step(v(0, 0,  0,  1,  0, 0, 0, 2, 0, 0));
    do_reset();
    step(v(0, 0, 0, 0,  0, 0, 0, 0, 0, 0));

    // random traffic against the model
    for (int c = 0; c < 600; c++) begin
      int num, p0, p1, hold;
      if (c % 120 == 0) do_reset();
      hold = ($urandom_range(0, 3) == 0) ? 1 : 0;
      num  = ($urandom_range(0, 39) == 0) ? 3 : $urandom_range(0, 2);
      if (((DEPTH - q.size()) < 2) && $urandom_range(0, 9) != 0) num = 0;
      p0 = ($urandom_range(0, 29) == 0) ? $urandom_range(96, 127) : $urandom_range(0, 95);
      p1 = ($urandom_range(0, 29) == 0) ? $urandom_range(96, 127) : $urandom_range(0, 95);
      step(mk(num, p0, p1, hold));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
